nec_ir_frame_decoder: RTL and testbench
=======================================

// Module: nec_ir_frame_decoder
// PURPOSE
//  Parametrised NEC infrared frame decoder for the IRDA_RXD line.
//  - Captures the full 32-bit frame (address, address/inverse, command, inverse command) and validates it.
//  - Detects repeat codes and reports timing or format errors.
//  - Feeds the LED animation controller a registered command byte with a one-cycle valid strobe,
//    replacing fixed-state command matching.
// PARAMETERS
//  SAMPLE_DIV     1000  clk cycles per sample tick (50 MHz -> 20 us tick)
//  CNT_W          10    width of segment-length counter, saturates at 2**CNT_W-1
//  LEAD_MARK_MIN  400   min leader mark length in ticks (8.0 ms)
//  LEAD_SPC_SPLIT 169   leader space >= value -> data frame, < value -> repeat (3.375 ms)
//  LEAD_SPC_MIN   90    min leader space in ticks (1.8 ms)
//  BIT_MARK_MAX   45    max bit mark in ticks (0.9 ms)
//  BIT_SPC_SPLIT  56    bit space >= value -> logic 1, < value -> logic 0 (1.125 ms)
//  SEG_TIMEOUT    350   any segment longer than this (7 ms) after leader is an error
//  ADDR_MATCH     16'h00FF  accepted address when NEC_ADDR_FILTER_EN is defined
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous active-low reset
//  w         in   1   raw IRDA_RXD, active-low mark (0 = carrier present)
//  addr      out  16  address of last accepted frame
//  cmd       out  8   command of last accepted frame
//  valid     out  1   1-clk pulse: new addr/cmd latched
//  rpt       out  1   1-clk pulse: repeat code after a valid frame
//  err       out  1   1-clk pulse: frame aborted (timing or inverse-check failure)
//  busy      out  1   high while FSM is not IDLE
// BEHAVIOUR
//  Reset:
//  - rst low: addr=0, cmd=0, valid=rpt=err=busy=0, FSM=IDLE, last_ok=0.
//  - Synchroniser flops = 1 and filter history = 111.
//  - Reset mid-frame discards the partial frame.
//  Input conditioning:
//  - w passes a 2-flop synchroniser.
//  - On each tick, 3-sample history and majority vote -> s (clean level).
//  - Edge = s differs from previous s.
//  - Counter clears on every edge and on every FSM transition.
//  - Otherwise +1 per tick, saturating.
//  - Tick is a 1-clk pulse from a modulo-SAMPLE_DIV divider.
//  - All FSM decisions happen on tick only.
//  FSM states:
//  - IDLE: s falls -> LMARK.
//  - LMARK: s rises with cnt >= LEAD_MARK_MIN -> LSPACE; rises earlier -> IDLE silently (noise, no err).
//  - LSPACE: s falls with cnt >= LEAD_SPC_SPLIT -> BMARK, bitcnt=0, shift=0.
//  - LSPACE: s falls with LEAD_SPC_MIN <= cnt < LEAD_SPC_SPLIT -> RSTOP.
//  - LSPACE: s falls with cnt < LEAD_SPC_MIN -> IDLE + err.
//  - BMARK: s rises with cnt <= BIT_MARK_MAX -> BSPACE; longer mark -> IDLE + err.
//  - BSPACE: s falls -> bit = (cnt >= BIT_SPC_SPLIT).
//    - Shift right into shift[31]; LSB is received first.
//    - bitcnt+1; bitcnt==31 -> STOP, else BMARK.
//  - STOP: s rises (stop-bit mark ends) -> check shift[31:24] == ~shift[23:16].
//    - Pass: addr=shift[15:0], cmd=shift[23:16], valid=1, last_ok=1.
//    - Fail: err=1, last_ok=0.
//    - Either way -> IDLE.
//  - RSTOP: s rises -> rpt=last_ok (no pulse if no prior good frame) -> IDLE.
//  - Any non-IDLE state with cnt > SEG_TIMEOUT -> IDLE, err=1, last_ok=0.
//  - LMARK and LSPACE use the rules above in place of SEG_TIMEOUT: no err from them.
//    LMARK timeout at saturation returns to IDLE.
//  Outputs and latency:
//  - valid/rpt/err are registered and asserted in the clk after the deciding tick.
//  - At most one of the three is high in any cycle.
//  - addr/cmd hold until the next valid.
//  - busy = (state != IDLE), registered.
//  Simultaneous events: the timeout check has priority over an edge in the same tick.
// CONFIGURATION
//  NEC_ADDR_FILTER_EN defined:
//  - After the inverse check passes, the frame is also required to have shift[15:0] == ADDR_MATCH.
//  - Mismatch: no valid, no err, last_ok=0 (foreign remote ignored); its repeats give no rpt.
//  NEC_ADDR_FILTER_EN undefined: every frame passing the inverse check is accepted.
// TESTING
//  (SAMPLE_DIV=1000, 50 MHz; times are at w)
//  1. Frame addr 16'h00FF, cmd 8'h16 (9 ms/4.5 ms leader, 562 us marks, 562/1687 us spaces, stop mark).
//     -> valid=1 for 1 clk, addr=16'h00FF, cmd=8'h16, err=0.
//  2. Test 1 then 9 ms/2.25 ms/562 us repeat 40 ms later -> rpt=1 once, cmd stays 8'h16.
//     Repeat after reset without a frame -> rpt stays 0.
//  3. Frame with byte3=8'h00, cmd=8'h16 (bad inverse) -> err=1 once, valid=0, addr/cmd unchanged.
//  4. Line held low 20 us glitches during the 4.5 ms space -> filtered, frame decodes as test 1.
//     Space stretched to 10 ms mid-frame -> err at 7 ms, busy falls.
//  5. rst low during bit 12, release, send test 1 frame -> single valid, correct values.
//  6. With NEC_ADDR_FILTER_EN, addr 16'h10EF cmd 8'h16 -> no valid/err.
//     Same frame with addr 16'h00FF -> valid.

Source files
------------

// File: rtl/nec_ir_frame_decoder_if.sv
// Purpose: bundles the IR receive line and the decoded-frame outputs of nec_ir_frame_decoder.
// Latency: none, signal bundle only.
// Backpressure: none; outputs are single-cycle strobes plus held addr/cmd registers.
interface nec_ir_frame_decoder_if;
  logic        w;
  logic [15:0] addr;
  logic [7:0]  cmd;
  logic        valid;
  logic        rpt;
  logic        err;
  logic        busy;

  // Decoder side: samples the line, drives results.
  modport master (input w, output addr, cmd, valid, rpt, err, busy);
  // Line driver / result consumer side.
  modport slave (output w, input addr, cmd, valid, rpt, err, busy);
endinterface

// File: rtl/nec_ir_frame_decoder.sv
// Purpose: NEC IR frame decoder (32-bit frame capture, inverse check, repeat detect); optional address filter via NEC_ADDR_FILTER_EN.
// Latency: valid/rpt/err assert one clk after the sample tick that sees the deciding edge (2-flop sync + 3-sample majority ahead of that).
// Backpressure: none; results are one-clk strobes, addr/cmd hold until the next accepted frame.
module nec_ir_frame_decoder #(
  parameter int unsigned SAMPLE_DIV     = 1000,
  parameter int unsigned CNT_W          = 10,
  parameter int unsigned LEAD_MARK_MIN  = 400,
  parameter int unsigned LEAD_SPC_SPLIT = 169,
  parameter int unsigned LEAD_SPC_MIN   = 90,
  parameter int unsigned BIT_MARK_MAX   = 45,
  parameter int unsigned BIT_SPC_SPLIT  = 56,
  parameter int unsigned SEG_TIMEOUT    = 350
`ifdef NEC_ADDR_FILTER_EN
  , parameter logic [15:0] ADDR_MATCH   = 16'h00FF
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  nec_ir_frame_decoder_if.master bus
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LMARK_C  = CNT_W'(LEAD_MARK_MIN);
  localparam logic [CNT_W-1:0] LSPLIT_C = CNT_W'(LEAD_SPC_SPLIT);
  localparam logic [CNT_W-1:0] LSMIN_C  = CNT_W'(LEAD_SPC_MIN);
  localparam logic [CNT_W-1:0] BMARK_C  = CNT_W'(BIT_MARK_MAX);
  localparam logic [CNT_W-1:0] BSPLIT_C = CNT_W'(BIT_SPC_SPLIT);
  localparam logic [CNT_W-1:0] SEGTO_C  = CNT_W'(SEG_TIMEOUT);

  typedef enum logic [2:0] {IDLE, LMARK, LSPACE, BMARK, BSPACE, STOP, RSTOP} state_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic             sync1_q, sync2_q;
  logic [2:0]       hist_q, hist_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic [31:0]      shift_q, shift_d;
  logic             last_ok_q, last_ok_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             valid_q, valid_d, rpt_q, rpt_d, err_q, err_d, busy_q, busy_d;

  logic       tick, s_new, rise, fall, timeout, inv_ok, addr_ok;
  logic [2:0] hist_new;

  assign tick     = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign hist_new = {hist_q[1:0], sync2_q};
  assign s_new    = (hist_new[0] & hist_new[1]) | (hist_new[0] & hist_new[2]) | (hist_new[1] & hist_new[2]);
  assign rise     = tick & s_new & ~s_q;
  assign fall     = tick & ~s_new & s_q;
  assign timeout  = (cnt_q > SEGTO_C);
  assign inv_ok   = (shift_q[31:24] == ~shift_q[23:16]);
`ifdef NEC_ADDR_FILTER_EN
  assign addr_ok  = (shift_q[15:0] == ADDR_MATCH);
`else
  assign addr_ok  = 1'b1;
`endif

  // Tick divider and majority-filtered line level, advanced once per tick.
  always_comb begin
    div_d  = tick ? '0 : div_q + DIV_W'(1);
    hist_d = tick ? hist_new : hist_q;
    s_d    = tick ? s_new : s_q;
  end

  // Frame FSM: every decision is gated by tick; the segment timeout outranks an edge.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    last_ok_d = last_ok_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    valid_d   = 1'b0;
    rpt_d     = 1'b0;
    err_d     = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: if (fall) state_d = LMARK;
        LMARK: begin
          // Too-short marks are treated as noise; a stuck-low line gives up silently.
          if (cnt_q == CNT_MAX) state_d = IDLE;
          else if (rise)        state_d = (cnt_q >= LMARK_C) ? LSPACE : IDLE;
        end
        LSPACE: begin
          if (cnt_q == CNT_MAX) state_d = IDLE;
          else if (fall) begin
            if (cnt_q >= LSPLIT_C) begin
              state_d  = BMARK;
              bitcnt_d = '0;
              shift_d  = '0;
            end else if (cnt_q >= LSMIN_C) begin
              state_d = RSTOP;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
        default: begin
          if (timeout) begin
            state_d   = IDLE;
            err_d     = 1'b1;
            last_ok_d = 1'b0;
          end else begin
            unique case (state_q)
              BMARK: if (rise) begin
                if (cnt_q <= BMARK_C) state_d = BSPACE;
                else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
                end
              end
              BSPACE: if (fall) begin
                // LSB arrives first, so each bit enters at the top and walks down.
                shift_d  = {(cnt_q >= BSPLIT_C), shift_q[31:1]};
                bitcnt_d = bitcnt_q + 5'd1;
                state_d  = (bitcnt_q == 5'd31) ? STOP : BMARK;
              end
              STOP: if (rise) begin
                state_d = IDLE;
                if (!inv_ok) begin
                  err_d     = 1'b1;
                  last_ok_d = 1'b0;
                end else if (addr_ok) begin
                  addr_d    = shift_q[15:0];
                  cmd_d     = shift_q[23:16];
                  valid_d   = 1'b1;
                  last_ok_d = 1'b1;
                end else begin
                  last_ok_d = 1'b0;
                end
              end
              RSTOP: if (rise) begin
                state_d = IDLE;
                rpt_d   = last_ok_q;
              end
              default: state_d = IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Segment length counter: restarts on any edge or state change, saturates otherwise.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = (state_d != IDLE);
    if (tick) begin
      if (rise || fall || (state_d != state_q)) cnt_d = '0;
      else if (cnt_q != CNT_MAX)                 cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers; synchroniser and filter idle high (no carrier).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      hist_q    <= 3'b111;
      s_q       <= 1'b1;
      cnt_q     <= '0;
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      last_ok_q <= 1'b0;
      addr_q    <= '0;
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      rpt_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      sync1_q   <= bus.w;
      sync2_q   <= sync1_q;
      hist_q    <= hist_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      last_ok_q <= last_ok_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      rpt_q     <= rpt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.addr  = addr_q;
  assign bus.cmd   = cmd_q;
  assign bus.valid = valid_q;
  assign bus.rpt   = rpt_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_nec_ir_frame_decoder.sv
// Purpose: self-checking bench for nec_ir_frame_decoder; expected result strobes are queued as frames are sent.
// Latency: results are checked whenever a strobe appears; each frame is drained within a bounded window.
// Backpressure: none; the bench drives the IR line directly through the interface.
module tb_nec_ir_frame_decoder;
  localparam int DIV        = 2;
  localparam int LEAD_MARK  = 450;
  localparam int LEAD_SPACE = 225;
  localparam int RPT_SPACE  = 112;
  localparam int BIT_MARK   = 28;
  localparam int ZERO_SPACE = 28;
  localparam int ONE_SPACE  = 84;
  localparam int GAP        = 60;
  localparam logic [1:0] EV_VALID = 2'd0, EV_RPT = 2'd1, EV_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  cmd;
  } ev_t;

  typedef struct packed {
    logic        is_rpt;
    logic [31:0] frame;
    logic        has_ev;
    ev_t         ev;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  vec_t vecs[7];

  nec_ir_frame_decoder_if bus ();
  nec_ir_frame_decoder #(.SAMPLE_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [31:0] f, input logic h,
                              input logic [1:0] k, input logic [15:0] a, input logic [7:0] c);
    vec_t v;
    v.is_rpt  = r;
    v.frame   = f;
    v.has_ev  = h;
    v.ev.kind = k;
    v.ev.addr = a;
    v.ev.cmd  = c;
    return v;
  endfunction

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t got, want;
    if (rst && (bus.valid || bus.rpt || bus.err)) begin
      check("pulse_onehot", $countones({bus.valid, bus.rpt, bus.err}), 1);
      got.kind = bus.valid ? EV_VALID : (bus.rpt ? EV_RPT : EV_ERR);
      got.addr = bus.addr;
      got.cmd  = bus.cmd;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d addr 0x%h cmd 0x%h, required none",
                 got.kind, got.addr, got.cmd);
      end else begin
        want = exp_q.pop_front();
        check("event_kind", 32'(got.kind), 32'(want.kind));
        check("event_addr", 32'(got.addr), 32'(want.addr));
        check("event_cmd",  32'(got.cmd),  32'(want.cmd));
      end
    end
  end

  task automatic seg(input logic lvl, input int ticks);
    bus.w = lvl;
    repeat (ticks * DIV) @(negedge clk);
  endtask

  task automatic send_leader(input bit glitch);
    seg(1'b0, LEAD_MARK);
    if (glitch) begin
      for (int g = 0; g < 5; g++) begin
        seg(1'b1, 40);
        seg(1'b0, 1);
      end
      seg(1'b1, LEAD_SPACE - 205);
    end else begin
      seg(1'b1, LEAD_SPACE);
    end
  endtask

  task automatic send_frame(input logic [31:0] f, input bit glitch);
    send_leader(glitch);
    for (int i = 0; i < 32; i++) begin
      seg(1'b0, BIT_MARK);
      seg(1'b1, f[i] ? ONE_SPACE : ZERO_SPACE);
    end
    seg(1'b0, BIT_MARK);
    seg(1'b1, GAP);
  endtask

  task automatic send_repeat();
    seg(1'b0, LEAD_MARK);
    seg(1'b1, RPT_SPACE);
    seg(1'b0, BIT_MARK);
    seg(1'b1, GAP);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    vecs[0] = mk(1'b0, 32'hE91600FF, 1'b1, EV_VALID, 16'h00FF, 8'h16);
    vecs[1] = mk(1'b1, 32'h0,        1'b1, EV_RPT,   16'h00FF, 8'h16);
    vecs[2] = mk(1'b0, 32'h001600FF, 1'b1, EV_ERR,   16'h00FF, 8'h16);
    vecs[3] = mk(1'b1, 32'h0,        1'b0, EV_RPT,   16'h00FF, 8'h16);
`ifdef NEC_ADDR_FILTER_EN
    vecs[4] = mk(1'b0, 32'hE91610EF, 1'b0, EV_VALID, 16'h00FF, 8'h16);
    vecs[5] = mk(1'b1, 32'h0,        1'b0, EV_RPT,   16'h00FF, 8'h16);
`else
    vecs[4] = mk(1'b0, 32'hE91610EF, 1'b1, EV_VALID, 16'h10EF, 8'h16);
    vecs[5] = mk(1'b1, 32'h0,        1'b1, EV_RPT,   16'h10EF, 8'h16);
`endif
    vecs[6] = mk(1'b0, 32'hBA4500FF, 1'b1, EV_VALID, 16'h00FF, 8'h45);

    // Reset state.
    bus.w = 1'b1;
    rst   = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_addr",  32'(bus.addr), 0);
    check("reset_cmd",   32'(bus.cmd), 0);
    check("reset_valid", 32'(bus.valid), 0);
    check("reset_rpt",   32'(bus.rpt), 0);
    check("reset_err",   32'(bus.err), 0);
    check("reset_busy",  32'(bus.busy), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Repeat code with no prior good frame: busy while active, no rpt.
    seg(1'b0, LEAD_MARK);
    check("busy_in_leader", 32'(bus.busy), 1);
    seg(1'b1, RPT_SPACE);
    seg(1'b0, BIT_MARK);
    seg(1'b1, GAP);
    check("busy_after_repeat", 32'(bus.busy), 0);
    wait_drain("repeat_no_frame_drain");

    // Table-driven frames and repeats.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].has_ev) exp_q.push_back(vecs[i].ev);
      if (vecs[i].is_rpt) send_repeat();
      else                send_frame(vecs[i].frame, 1'b0);
      wait_drain($sformatf("vec%0d_drain", i));
    end

    // Single-sample glitches inside the leader space are filtered out.
    e.kind = EV_VALID; e.addr = 16'h00FF; e.cmd = 8'h16;
    exp_q.push_back(e);
    send_frame(32'hE91600FF, 1'b1);
    wait_drain("glitch_frame_drain");

    // Stretched bit space: error only once the segment exceeds the timeout.
    e.kind = EV_ERR; e.addr = 16'h00FF; e.cmd = 8'h16;
    exp_q.push_back(e);
    send_leader(1'b0);
    for (int i = 0; i < 4; i++) begin
      seg(1'b0, BIT_MARK);
      seg(1'b1, ONE_SPACE);
    end
    seg(1'b0, BIT_MARK);
    seg(1'b1, 300);
    check("no_err_before_timeout", exp_q.size(), 1);
    check("busy_before_timeout", 32'(bus.busy), 1);
    seg(1'b1, 200);
    wait_drain("timeout_err_drain");
    check("busy_after_timeout", 32'(bus.busy), 0);

    // Reset during bit 12 discards the partial frame; a following frame decodes once.
    fork
      send_frame(32'hE91600FF, 1'b0);
      begin
        repeat ((LEAD_MARK + LEAD_SPACE + 8 * (BIT_MARK + ONE_SPACE)
                 + 4 * (BIT_MARK + ZERO_SPACE) + 10) * DIV) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset_addr", 32'(bus.addr), 0);
        check("midreset_cmd",  32'(bus.cmd), 0);
        check("midreset_busy", 32'(bus.busy), 0);
        rst = 1'b1;
      end
    join
    wait_drain("partial_frame_drain");
    e.kind = EV_VALID; e.addr = 16'h00FF; e.cmd = 8'h16;
    exp_q.push_back(e);
    send_frame(32'hE91600FF, 1'b0);
    wait_drain("after_reset_frame_drain");
    check("final_addr", 32'(bus.addr), 32'h00FF);
    check("final_cmd",  32'(bus.cmd), 32'h16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
